// File: rtl/serial_7seg_receiver.sv
// Display-link receiver: synchronizes data/clk/latch, deserializes NUM_DIGITS bytes per frame.
// Optional seven-segment decode of the latched bytes is built when SERIAL_7SEG_DECODE_EN is defined.
module serial_7seg_receiver #(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_serial_data,
  input  logic                    i_serial_clk,
  input  logic                    i_serial_latch,
  output logic [NUM_DIGITS*8-1:0] o_digits,
  output logic                    o_frame_valid,
  output logic                    o_frame_err,
`ifdef SERIAL_7SEG_DECODE_EN
  output logic [NUM_DIGITS*4-1:0] o_bcd,
  output logic                    o_seg_err,
`endif
  output logic [7:0]              o_frame_cnt
);

  localparam int N  = NUM_DIGITS * 8;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(N);
  localparam logic [CW-1:0] SAT_CNT  = CW'(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] latch_sync_r;
  logic                   clk_prev_r;
  logic                   latch_prev_r;
  logic [N-1:0]           shift_r;
  logic [CW-1:0]          cnt_r;

  logic                   data_s;
  logic                   clk_rise_s;
  logic                   latch_rise_s;
  logic [N-1:0]           shift_next_s;
  logic [CW-1:0]          cnt_inc_s;

  // Synchronizer chains plus one edge-detect flop per control line
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_sync_r  <= '0;
      clk_sync_r   <= '0;
      latch_sync_r <= '0;
      clk_prev_r   <= 1'b0;
      latch_prev_r <= 1'b0;
    end else begin
      data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], i_serial_data};
      clk_sync_r   <= {clk_sync_r[SYNC_STAGES-2:0], i_serial_clk};
      latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], i_serial_latch};
      clk_prev_r   <= clk_sync_r[SYNC_STAGES-1];
      latch_prev_r <= latch_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge detection, next shift value and saturating bit count
  always_comb begin
    data_s       = data_sync_r[SYNC_STAGES-1];
    clk_rise_s   = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
    latch_rise_s = latch_sync_r[SYNC_STAGES-1] & ~latch_prev_r;
    shift_next_s = {shift_r[N-2:0], data_s};
    if (cnt_r == SAT_CNT) begin
      cnt_inc_s = SAT_CNT;
    end else begin
      cnt_inc_s = cnt_r + CW'(1);
    end
  end

`ifdef SERIAL_7SEG_DECODE_EN
  logic [NUM_DIGITS*4-1:0] bcd_s;
  logic                    seg_err_s;

  // Returns {invalid, value}; the dp bit is ignored
  function automatic logic [4:0] seg_decode(input logic [7:0] seg);
    logic [4:0] res;
    case (seg[6:0])
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h6F:   res = 5'h09;
      default: res = 5'h1F;
    endcase
    return res;
  endfunction

  // Decode every byte of the shift register; captured only on a good frame
  always_comb begin
    logic [4:0] dec_s;
    bcd_s     = '0;
    seg_err_s = 1'b0;
    dec_s     = 5'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dec_s            = seg_decode(shift_r[8*k +: 8]);
      bcd_s[4*k +: 4]  = dec_s[3:0];
      seg_err_s        = seg_err_s | dec_s[4];
    end
  end
`endif

  // Frame FSM: shift on clk edges, judge the bit count in the single LATCH cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      shift_r       <= '0;
      cnt_r         <= '0;
      o_digits      <= '0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_frame_cnt   <= 8'd0;
`ifdef SERIAL_7SEG_DECODE_EN
      o_bcd         <= '0;
      o_seg_err     <= 1'b0;
`endif
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_SHIFT: begin
          if (clk_rise_s) begin
            shift_r <= shift_next_s;
            cnt_r   <= cnt_inc_s;
          end
          if (latch_rise_s) begin
            state_r <= ST_LATCH;
          end else if (clk_rise_s) begin
            state_r <= ST_SHIFT;
          end else begin
            state_r <= state_r;
          end
        end
        ST_LATCH: begin
          if (cnt_r == FULL_CNT) begin
            o_digits      <= shift_r;
            o_frame_valid <= 1'b1;
            o_frame_cnt   <= o_frame_cnt + 8'd1;
`ifdef SERIAL_7SEG_DECODE_EN
            o_bcd         <= bcd_s;
            o_seg_err     <= seg_err_s;
`endif
          end else begin
            o_frame_err <= 1'b1;
          end
          // A clk edge here already belongs to the next frame
          if (clk_rise_s) begin
            shift_r <= shift_next_s;
            cnt_r   <= CW'(1);
          end else begin
            cnt_r   <= '0;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_7seg_receiver.sv
// Scoreboard bench for serial_7seg_receiver: expected frame results are queued at latch time
// and compared when the receiver pulses o_frame_valid / o_frame_err.
`timescale 1ns/1ps
module tb_serial_7seg_receiver;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_serial_data = 1'b0;
  logic        i_serial_clk = 1'b0;
  logic        i_serial_latch = 1'b0;
  logic [47:0] o_digits;
  logic        o_frame_valid;
  logic        o_frame_err;
  logic [7:0]  o_frame_cnt;
`ifdef SERIAL_7SEG_DECODE_EN
  logic [23:0] o_bcd;
  logic        o_seg_err;
`endif

  serial_7seg_receiver dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_serial_data  (i_serial_data),
    .i_serial_clk   (i_serial_clk),
    .i_serial_latch (i_serial_latch),
    .o_digits       (o_digits),
    .o_frame_valid  (o_frame_valid),
    .o_frame_err    (o_frame_err),
`ifdef SERIAL_7SEG_DECODE_EN
    .o_bcd          (o_bcd),
    .o_seg_err      (o_seg_err),
`endif
    .o_frame_cnt    (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        err;
    logic [47:0] digits;
    logic [7:0]  cnt;
    logic [23:0] bcd;
    logic        seg_err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          latch_cyc = 0;
  int          bits_sent = 0;
  logic [47:0] model_sr = 48'd0;
  logic [47:0] exp_digits = 48'd0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [23:0] exp_bcd = 24'd0;
  logic        exp_seg_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_seg(input logic [7:0] s);
    logic [7:0] m;
    m = s & 8'h7F;
    case (m)
      8'h3F: return 5'h00;
      8'h06: return 5'h01;
      8'h5B: return 5'h02;
      8'h4F: return 5'h03;
      8'h66: return 5'h04;
      8'h6D: return 5'h05;
      8'h7D: return 5'h06;
      8'h07: return 5'h07;
      8'h7F: return 5'h08;
      8'h6F: return 5'h09;
      default: return 5'h1F;
    endcase
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard consumer
  always @(negedge i_clk) begin
    if (!i_reset && (o_frame_valid || o_frame_err)) begin
      chk("exclusive_pulses", {63'd0, o_frame_valid & o_frame_err}, 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {62'd0, o_frame_valid, o_frame_err}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_kind", {63'd0, o_frame_err}, {63'd0, mon_e.err});
        chk("latch_latency", 64'(cyc - latch_cyc), 64'd4);
        chk("digits", {16'd0, o_digits}, {16'd0, mon_e.digits});
        chk("frame_cnt", {56'd0, o_frame_cnt}, {56'd0, mon_e.cnt});
`ifdef SERIAL_7SEG_DECODE_EN
        chk("bcd", {40'd0, o_bcd}, {40'd0, mon_e.bcd});
        chk("seg_err", {63'd0, o_seg_err}, {63'd0, mon_e.seg_err});
`endif
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic push_exp();
    logic [4:0] r;
    exp_t e;
    if (bits_sent == 48) begin
      exp_digits  = model_sr;
      exp_cnt     = exp_cnt + 8'd1;
      exp_seg_err = 1'b0;
      for (int k = 0; k < 6; k++) begin
        r = ref_seg(model_sr[8*k +: 8]);
        exp_bcd[4*k +: 4] = r[3:0];
        exp_seg_err = exp_seg_err | r[4];
      end
    end
    e.err     = (bits_sent != 48);
    e.digits  = exp_digits;
    e.cnt     = exp_cnt;
    e.bcd     = exp_bcd;
    e.seg_err = exp_seg_err;
    sb_q.push_back(e);
  endtask

  task automatic shift_bit(input logic b, input bit with_latch);
    i_serial_data = b;
    i_serial_clk  = 1'b0;
    model_sr  = {model_sr[46:0], b};
    bits_sent = bits_sent + 1;
    wait_neg(3);
    if (with_latch) begin
      push_exp();
      i_serial_latch = 1'b1;
      latch_cyc = cyc;
    end
    i_serial_clk = 1'b1;
    wait_neg(3);
  endtask

  task automatic finish_latch(input bit already);
    i_serial_clk = 1'b0;
    if (!already) begin
      push_exp();
      i_serial_latch = 1'b1;
      latch_cyc = cyc;
      wait_neg(3);
    end
    i_serial_latch = 1'b0;
    bits_sent = 0;
    wait_neg(3);
    for (int t = 0; t < 30 && sb_q.size() != 0; t++) @(negedge i_clk);
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    chk("digits_steady", {16'd0, o_digits}, {16'd0, exp_digits});
    chk("cnt_steady", {56'd0, o_frame_cnt}, {56'd0, exp_cnt});
  endtask

  task automatic send_frame(input int nbits, input logic [47:0] data, input bit coincide);
    for (int i = 0; i < nbits; i++) begin
      shift_bit(data[(nbits - 1 - i) % 48], coincide && (i == nbits - 1));
    end
    finish_latch(coincide);
  endtask

  task automatic check_reset_outputs();
    chk("rst_digits", {16'd0, o_digits}, 64'd0);
    chk("rst_valid", {63'd0, o_frame_valid}, 64'd0);
    chk("rst_err", {63'd0, o_frame_err}, 64'd0);
    chk("rst_cnt", {56'd0, o_frame_cnt}, 64'd0);
`ifdef SERIAL_7SEG_DECODE_EN
    chk("rst_bcd", {40'd0, o_bcd}, 64'd0);
    chk("rst_seg_err", {63'd0, o_seg_err}, 64'd0);
`endif
  endtask

  initial begin
    wait_neg(3);
    check_reset_outputs();
    i_reset = 1'b0;
    wait_neg(4);

    // Basic frame: digits 1..6
    send_frame(48, 48'h065B4F666D7D, 1'b0);
    chk("t1_digits", {16'd0, o_digits}, 64'h0000_065B_4F66_6D7D);
    chk("t1_cnt", {56'd0, o_frame_cnt}, 64'd1);
`ifdef SERIAL_7SEG_DECODE_EN
    chk("t1_bcd", {40'd0, o_bcd}, 64'h123456);
    chk("t1_seg_err", {63'd0, o_seg_err}, 64'd0);
`endif

    // Short frame, then a good one
    send_frame(47, 48'hA5A5_5A5A_F00F, 1'b0);
    chk("t2_hold", {16'd0, o_digits}, 64'h0000_065B_4F66_6D7D);
    send_frame(48, 48'h3F067D4F6F07, 1'b0);

    // Long frame and empty latch
    send_frame(60, 48'h1234_5678_9ABC, 1'b0);
    send_frame(0, 48'd0, 1'b0);

    // Reset in the middle of a frame
    for (int i = 0; i < 20; i++) shift_bit(1'(i % 3 == 0), 1'b0);
    i_reset = 1'b1;
    #1;
    check_reset_outputs();
    i_serial_clk  = 1'b0;
    i_serial_data = 1'b0;
    wait_neg(4);
    i_reset     = 1'b0;
    model_sr    = 48'd0;
    bits_sent   = 0;
    exp_digits  = 48'd0;
    exp_cnt     = 8'd0;
    exp_bcd     = 24'd0;
    exp_seg_err = 1'b0;
    wait_neg(4);
    send_frame(48, 48'h6D7D07667F3F, 1'b0);

    // Last clk edge together with the latch edge
    send_frame(48, 48'h5B5B4F4F0606, 1'b1);

    // Invalid segment pattern plus dp on a valid digit
    send_frame(48, 48'h3FC986077F6F, 1'b0);
`ifdef SERIAL_7SEG_DECODE_EN
    chk("t6_bcd", {40'd0, o_bcd}, 64'h0F1789);
    chk("t6_seg_err", {63'd0, o_seg_err}, 64'd1);
`endif

    // Good frames until the counter wraps
    for (int f = 0; f < 300; f++) begin
      send_frame(48, {$urandom, $urandom}, 1'b0);
      if (exp_cnt == 8'd0) break;
    end
    chk("cnt_wrap", {56'd0, o_frame_cnt}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
